// File: rtl/memory_access_controller_pkg.sv
// memory_access_controller_pkg
// Shared definitions for the memory access controller slice.
//   N_DEFAULT / M_DEFAULT : default address and data widths
//   state_t               : controller states with fixed 2-bit encodings
//   REQ_F / REQ_D         : bit positions of the two requesters in request/grant vectors
//   rr_pick               : two-way round-robin grant selection
package memory_access_controller_pkg;

  localparam int N_DEFAULT = 4;
  localparam int M_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'b00,
    ST_RUN   = 2'b01
  } state_t;

  localparam int REQ_F = 0;
  localparam int REQ_D = 1;

  // One-hot grant for two requesters. On contention, the requester that
  // was not granted last wins, so fetch_last=1 hands the tie to data.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic fetch_last);
    logic [1:0] pick;
    pick = 2'b00;
    if (req[REQ_F] && req[REQ_D]) begin
      pick = fetch_last ? 2'b10 : 2'b01;
    end else if (req[REQ_F]) begin
      pick = 2'b01;
    end else if (req[REQ_D]) begin
      pick = 2'b10;
    end
    return pick;
  endfunction

endpackage

// File: rtl/memory_access_controller_if.sv
// memory_access_controller_if
// Bundles the requester handshakes and the external memory port.
//   Fetch requester : req_f, addr_f -> gnt_f, rvalid_f
//   Data requester  : req_d, we_d, addr_d, wdata_d -> gnt_d, rvalid_d
//   Shared          : rdata (registered read data), busy (clear sweep running)
//   Memory port     : mem_en, mem_we, mem_addr, mem_wdata -> mem_rdata
// Modports:
//   slave  : the controller side
//   master : the requesters plus the external memory that surround it
interface memory_access_controller_if
  import memory_access_controller_pkg::*;
#(
  parameter int n = N_DEFAULT,
  parameter int m = M_DEFAULT
);

  logic         req_f;
  logic [n-1:0] addr_f;
  logic         req_d;
  logic         we_d;
  logic [n-1:0] addr_d;
  logic [m-1:0] wdata_d;

  logic         gnt_f;
  logic         gnt_d;
  logic         rvalid_f;
  logic         rvalid_d;
  logic [m-1:0] rdata;
  logic         busy;

  logic         mem_en;
  logic         mem_we;
  logic [n-1:0] mem_addr;
  logic [m-1:0] mem_wdata;
  logic [m-1:0] mem_rdata;

  modport slave (
    input  req_f, addr_f, req_d, we_d, addr_d, wdata_d, mem_rdata,
    output gnt_f, gnt_d, rvalid_f, rvalid_d, rdata, busy,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_f, addr_f, req_d, we_d, addr_d, wdata_d, mem_rdata,
    input  gnt_f, gnt_d, rvalid_f, rvalid_d, rdata, busy,
           mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/memory_access_controller_rr_arbiter.sv
// rr_arbiter_2
// Two-way round-robin arbiter with a one-hot, combinational grant.
//   clk : clock
//   clr : synchronous active-high reset; leaves the arbiter favouring fetch
//   en  : grants are only issued while en=1
//   req : {data, fetch} request vector
//   gnt : {data, fetch} one-hot grant vector, valid in the same cycle as req
module rr_arbiter_2
  import memory_access_controller_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // Remembers who won the most recent grant; 0 after reset means data
  // is treated as the last winner, so fetch gets the first tie.
  logic fetch_last;

  // Grant selection is purely combinational so a lone requester is served
  // in the cycle it asks.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      gnt = rr_pick(req, fetch_last);
    end
  end

  // The pointer only moves when someone is actually granted; idle cycles
  // and disabled cycles leave the priority where it was.
  always_ff @(posedge clk) begin
    if (clr) begin
      fetch_last <= 1'b0;
    end else if (gnt != 2'b00) begin
      fetch_last <= gnt[REQ_F];
    end
  end

endmodule

// File: rtl/memory_access_controller.sv
// memory_access_controller
// Arbitrates a fetch (read-only) requester and a data (read/write) requester
// onto one external single-port memory. After reset the whole memory is
// swept to zero, one word per cycle, before any request is accepted.
//   clk : clock, all state updates on the rising edge
//   clr : synchronous active-high reset; restarts the clear sweep
//   bus : memory_access_controller_if.slave
//         request/grant handshakes, shared registered rdata with per-requester
//         rvalid, busy during the sweep, and the external memory port
// Parameters:
//   n : address width, memory depth is 2**n words
//   m : data width
module memory_access_controller
  import memory_access_controller_pkg::*;
#(
  parameter int n = N_DEFAULT,
  parameter int m = M_DEFAULT
) (
  input  logic                        clk,
  input  logic                        clr,
  memory_access_controller_if.slave   bus
);

  localparam int           L         = 1 << n;
  localparam logic [n-1:0] LAST_ADDR = n'(L - 1);

  state_t       state;
  state_t       state_next;
  logic [n-1:0] sweep_cnt;
  logic [n-1:0] sweep_cnt_next;

  logic         arb_en;
  logic [1:0]   req;
  logic [1:0]   gnt;
  logic         rd_grant;

  logic         busy;
  logic         mem_en;
  logic         mem_we;
  logic [n-1:0] mem_addr;
  logic [m-1:0] mem_wdata;

  logic [m-1:0] rdata_q;
  logic         rvalid_f_q;
  logic         rvalid_d_q;

  assign req      = {bus.req_d, bus.req_f};
  // Arbitration is gated by the registered state only, which keeps the
  // grant path free of any loop through the output decode below.
  assign arb_en   = (state == ST_RUN);
  assign rd_grant = gnt[REQ_F] | (gnt[REQ_D] & ~bus.we_d);

  rr_arbiter_2 u_arbiter (
    .clk (clk),
    .clr (clr),
    .en  (arb_en),
    .req (req),
    .gnt (gnt)
  );

  // State and sweep counter registers.
  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= ST_CLEAR;
      sweep_cnt <= '0;
    end else begin
      state     <= state_next;
      sweep_cnt <= sweep_cnt_next;
    end
  end

  // Next-state and memory port decode. In CLEAR the memory port writes zero
  // to the sweep address; in RUN it carries whichever requester won this
  // cycle, or sits fully idle with address and data at zero.
  always_comb begin
    state_next     = state;
    sweep_cnt_next = sweep_cnt;
    busy           = 1'b0;
    mem_en         = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;

    case (state)
      ST_CLEAR: begin
        busy     = 1'b1;
        mem_en   = 1'b1;
        mem_we   = 1'b1;
        mem_addr = sweep_cnt;
        if (sweep_cnt == LAST_ADDR) begin
          state_next     = ST_RUN;
          sweep_cnt_next = '0;
        end else begin
          sweep_cnt_next = sweep_cnt + 1'b1;
        end
      end

      ST_RUN: begin
        if (gnt[REQ_F]) begin
          mem_en   = 1'b1;
          mem_addr = bus.addr_f;
        end else if (gnt[REQ_D]) begin
          mem_en    = 1'b1;
          mem_we    = bus.we_d;
          mem_addr  = bus.addr_d;
          mem_wdata = bus.wdata_d;
        end
      end

      default: begin
        state_next     = ST_CLEAR;
        sweep_cnt_next = '0;
      end
    endcase
  end

  // Read return path. rdata is shared and only reloads on a granted read,
  // so a write leaves the last returned value visible. A reset edge drops
  // any read that was granted in the same cycle.
  always_ff @(posedge clk) begin
    if (clr) begin
      rdata_q    <= '0;
      rvalid_f_q <= 1'b0;
      rvalid_d_q <= 1'b0;
    end else begin
      rvalid_f_q <= gnt[REQ_F];
      rvalid_d_q <= gnt[REQ_D] & ~bus.we_d;
      if (rd_grant) begin
        rdata_q <= bus.mem_rdata;
      end
    end
  end

  assign bus.gnt_f     = gnt[REQ_F];
  assign bus.gnt_d     = gnt[REQ_D];
  assign bus.rvalid_f  = rvalid_f_q;
  assign bus.rvalid_d  = rvalid_d_q;
  assign bus.rdata     = rdata_q;
  assign bus.busy      = busy;
  assign bus.mem_en    = mem_en;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;

endmodule

// File: tb/tb_memory_access_controller.sv
// tb_memory_access_controller
// Drives the controller with directed scenarios and randomized traffic,
// models the external memory, and compares every cycle against a
// behavioural reference of the controller.
module tb_memory_access_controller;
  import memory_access_controller_pkg::*;

  localparam int N = 4;
  localparam int M = 16;
  localparam int L = 1 << N;

  logic clk = 1'b0;
  logic clr;

  memory_access_controller_if #(.n(N), .m(M)) bus ();

  memory_access_controller #(.n(N), .m(M)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // External memory: combinational read while enabled, write on the edge.
  // Seeded with random contents so the clear sweep is observable.
  logic [M-1:0] ext_mem [L];
  bit           mem_seeded = 1'b0;

  assign bus.mem_rdata = bus.mem_en ? ext_mem[bus.mem_addr] : M'(16'hDEAD);

  always @(posedge clk) begin
    if (!mem_seeded) begin
      for (int i = 0; i < L; i++) ext_mem[i] <= M'($urandom);
      mem_seeded <= 1'b1;
    end else if (bus.mem_en === 1'b1 && bus.mem_we === 1'b1) begin
      ext_mem[bus.mem_addr] <= bus.mem_wdata;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural reference: sweep progress, who won last, pending read
  // return and the memory contents as the controller should have left them.
  bit           m_known      = 1'b0;
  bit           m_busy       = 1'b1;
  int           m_cnt        = 0;
  bit           m_fetch_last = 1'b0;
  bit           m_rvalid_f   = 1'b0;
  bit           m_rvalid_d   = 1'b0;
  logic [M-1:0] m_rdata      = '0;
  logic [M-1:0] m_mem [L];

  task automatic expectEq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit c, input bit rf, input logic [N-1:0] af,
                               input bit rd, input bit wd, input logic [N-1:0] ad,
                               input logic [M-1:0] wdat);
    @(negedge clk);
    clr         = c;
    bus.req_f   = rf;
    bus.addr_f  = af;
    bus.req_d   = rd;
    bus.we_d    = wd;
    bus.addr_d  = ad;
    bus.wdata_d = wdat;
  endtask

  task automatic idle(input bit c);
    applyStimulus(c, 1'b0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  // Compares the current outputs with the reference, then advances the
  // reference across the coming rising edge using the same inputs.
  task automatic checkOutput();
    bit           g_f, g_d, e_en, e_we, rd;
    logic [N-1:0] e_addr;
    logic [M-1:0] e_wdata, rd_val;
    g_f = 0; g_d = 0; e_en = 0; e_we = 0; e_addr = '0; e_wdata = '0;

    if (m_busy) begin
      e_en = 1; e_we = 1; e_addr = N'(m_cnt);
    end else begin
      if (bus.req_f && bus.req_d) begin
        if (m_fetch_last) g_d = 1; else g_f = 1;
      end else if (bus.req_f) begin
        g_f = 1;
      end else if (bus.req_d) begin
        g_d = 1;
      end
      if (g_f) begin e_en = 1; e_addr = bus.addr_f; end
      if (g_d) begin e_en = 1; e_we = bus.we_d; e_addr = bus.addr_d; e_wdata = bus.wdata_d; end
    end

    if (m_known) begin
      expectEq("busy",      bus.busy,      m_busy);
      expectEq("gnt_f",     bus.gnt_f,     g_f);
      expectEq("gnt_d",     bus.gnt_d,     g_d);
      expectEq("mem_en",    bus.mem_en,    e_en);
      expectEq("mem_we",    bus.mem_we,    e_we);
      expectEq("mem_addr",  bus.mem_addr,  e_addr);
      expectEq("mem_wdata", bus.mem_wdata, e_wdata);
      expectEq("rvalid_f",  bus.rvalid_f,  m_rvalid_f);
      expectEq("rvalid_d",  bus.rvalid_d,  m_rvalid_d);
      expectEq("rdata",     bus.rdata,     m_rdata);
    end

    if (m_known || clr) begin
      rd     = g_f || (g_d && !bus.we_d);
      rd_val = m_mem[e_addr];
      if (e_en && e_we) m_mem[e_addr] = e_wdata;
      if (clr) begin
        m_known = 1; m_busy = 1; m_cnt = 0; m_fetch_last = 0;
        m_rvalid_f = 0; m_rvalid_d = 0; m_rdata = '0;
      end else begin
        m_rvalid_f = g_f;
        m_rvalid_d = g_d && !bus.we_d;
        if (rd) m_rdata = rd_val;
        if (m_busy) begin
          if (m_cnt == L - 1) begin m_busy = 0; m_cnt = 0; end
          else m_cnt++;
        end else if (g_f || g_d) begin
          m_fetch_last = g_f;
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < L; i++) m_mem[i] = '0;
    forever begin
      @(negedge clk);
      #4;
      checkOutput();
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clr = 1'b1;
    bus.req_f = 0; bus.addr_f = '0; bus.req_d = 0; bus.we_d = 0; bus.addr_d = '0; bus.wdata_d = '0;
    idle(1'b1);
    idle(1'b1);

    // Reset sweep: sixteen zero writes walking addresses 0..15.
    for (int i = 0; i < L; i++) begin
      idle(1'b0);
      #4;
      expectEq("sweep_busy",  bus.busy,      1);
      expectEq("sweep_addr",  bus.mem_addr,  i);
      expectEq("sweep_we",    bus.mem_we,    1);
      expectEq("sweep_wdata", bus.mem_wdata, 0);
    end

    // Single fetch read of address 3 right after the sweep.
    applyStimulus(0, 1, 4'd3, 0, 0, '0, '0);
    #4;
    expectEq("post_sweep_busy", bus.busy,  0);
    expectEq("read3_gnt_f",     bus.gnt_f, 1);
    expectEq("read3_mem_addr",  bus.mem_addr, 3);
    idle(0);
    #4;
    expectEq("read3_rvalid_f", bus.rvalid_f, 1);
    expectEq("read3_rdata",    bus.rdata,    16'h0000);

    // Data write of 0xBEEF to 5 followed directly by a read of 5.
    applyStimulus(0, 0, '0, 1, 1, 4'd5, 16'hBEEF);
    #4;
    expectEq("wr5_gnt_d",  bus.gnt_d,  1);
    expectEq("wr5_mem_we", bus.mem_we, 1);
    applyStimulus(0, 0, '0, 1, 0, 4'd5, '0);
    #4;
    expectEq("wr5_no_rvalid", bus.rvalid_d, 0);
    idle(0);
    #4;
    expectEq("rd5_rvalid_d", bus.rvalid_d, 1);
    expectEq("rd5_rdata",    bus.rdata,    16'hBEEF);

    // Contention for four cycles: f, d, f, d.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 4'd1, 1, 0, 4'd2, '0);
      #4;
      expectEq("rr_gnt_f",   bus.gnt_f,  (i % 2 == 0));
      expectEq("rr_gnt_d",   bus.gnt_d,  (i % 2 == 1));
      expectEq("rr_one_acc", bus.mem_en, 1);
    end

    // Reset during a granted fetch read, with fetch held through the sweep.
    applyStimulus(1, 1, 4'd7, 0, 0, '0, '0);
    #4;
    expectEq("clr_cycle_gnt_f", bus.gnt_f, 1);
    for (int i = 0; i < L; i++) begin
      applyStimulus(0, 1, 4'd7, 0, 0, '0, '0);
      #4;
      if (i == 0) expectEq("clr_dropped_rvalid", bus.rvalid_f, 0);
      expectEq("resweep_addr",  bus.mem_addr, i);
      expectEq("resweep_gnt_f", bus.gnt_f,    0);
    end
    applyStimulus(0, 1, 4'd7, 0, 0, '0, '0);
    #4;
    expectEq("held_req_busy",  bus.busy,  0);
    expectEq("held_req_gnt_f", bus.gnt_f, 1);
    idle(0);
    #4;
    expectEq("held_req_rvalid", bus.rvalid_f, 1);
    expectEq("held_req_rdata",  bus.rdata,    0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 99) == 0),
                    ($urandom_range(0, 9) < 6), N'($urandom_range(0, L - 1)),
                    ($urandom_range(0, 9) < 6), 1'($urandom_range(0, 1)),
                    N'($urandom_range(0, L - 1)), M'($urandom));
    end

    // Reset held high pins the sweep at address 0.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 1, 4'd9, 1, 1, 4'd4, 16'h1234);
      #4;
      if (i > 0) begin
        expectEq("hold_clr_addr", bus.mem_addr, 0);
        expectEq("hold_clr_busy", bus.busy,     1);
        expectEq("hold_clr_gnt",  {bus.gnt_d, bus.gnt_f}, 0);
      end
    end
    for (int i = 0; i < L; i++) idle(0);
    idle(0);
    #4;
    expectEq("final_busy", bus.busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_access_controller.md
MEMORY_ACCESS_CONTROLLER -- requirements
Module: memory_access_controller

Interface
REQ-001 Parameter: n, 4, address width in bits; depth L = 2**n words.
REQ-002 Parameter: m, 16, data width in bits.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 clr  in  1  synchronous, active-high reset; sampled on posedge clk.
REQ-005 req_f  in  1  fetch requester read request.
REQ-006 addr_f  in  n  fetch address.
REQ-007 req_d  in  1  data requester request.
REQ-008 we_d  in  1  data request is a write when 1, a read when 0.
REQ-009 addr_d  in  n  data address.
REQ-010 wdata_d  in  m  data write value.
REQ-011 gnt_f, gnt_d  out  1 each  request accepted this cycle (combinational).
REQ-012 rvalid_f, rvalid_d  out  1 each  read data valid for that requester.
REQ-013 rdata  out  m  registered read data, shared by both requesters.
REQ-014 mem_en, mem_we  out  1 each  memory enable / write strobe.
REQ-015 mem_addr  out  n  memory address.
REQ-016 mem_wdata  out  m  memory write data.
REQ-017 mem_rdata  in  m  memory read data; valid combinationally while mem_en=1.
REQ-018 busy  out  1  high while the clear sweep runs.

Function
REQ-019 States: CLEAR, RUN; 2-bit encoding, values fixed in the package.
REQ-020 CLEAR: mem_en=1, mem_we=1, mem_wdata=0, mem_addr=sweep counter; counter increments each cycle from 0 to L-1.
REQ-021 CLEAR -> RUN on the cycle after address L-1 is written; a full sweep takes exactly L cycles.
REQ-022 CLEAR: gnt_f=gnt_d=0, busy=1; requests are ignored, not queued; requesters hold them.
REQ-023 RUN: at most one grant per cycle; one access per cycle; no idle cycle between back-to-back grants.
REQ-024 Single requester active: it is granted in the same cycle.
REQ-025 Both active: round-robin; the requester not granted last wins; the pointer resets to favour fetch.
REQ-026 Pointer updates only on a grant; with no requests it holds.
REQ-027 Granted cycle: mem_en=1; mem_addr, mem_we (0 for fetch, we_d for data) and mem_wdata come from the winner.
REQ-028 No grant in RUN: mem_en=0, mem_we=0; mem_addr and mem_wdata = 0.
REQ-029 Granted read: rdata <= mem_rdata at posedge; the matching rvalid is 1 for exactly the following cycle (latency 1).
REQ-030 Granted write: no rvalid; rdata holds its previous value.
REQ-031 Write then read of the same address in consecutive cycles returns the new value.
REQ-032 Address wrap: addresses are n-bit; no out-of-range case exists.

Reset
REQ-033 clr=1 at posedge: state <= CLEAR, counter <= 0, pointer <= fetch, rdata <= 0, rvalid_f/rvalid_d <= 0.
REQ-034 clr asserted mid-sweep or mid-RUN: in-flight access is dropped (no rvalid) and a full sweep restarts from 0.
REQ-035 clr held high: the controller stays at counter 0; busy=1; memory address 0 is rewritten each cycle.

Structure
REQ-036 A shared package holds the default n and m values and the state encodings.
REQ-037 One sub-module, rr_arbiter_2: two requests in, one-hot grant out, last-grant pointer register.
REQ-038 The memory is external; this block contains no storage array.

Verification
REQ-039 Reset sweep: pulse clr, n=4 -> busy=1 for 16 cycles, mem_addr 0..15, mem_we=1, mem_wdata=0, then busy=0.
REQ-040 Single read: after the sweep, req_f=1, addr_f=3 -> gnt_f same cycle; rvalid_f next cycle; rdata=0x0000.
REQ-041 Write/read: req_d, we_d=1, addr_d=5, wdata_d=0xBEEF; next cycle a read of 5 -> rdata=0xBEEF, rvalid_d=1.
REQ-042 Contention: req_f and req_d held 4 cycles -> grants f,d,f,d; one access per cycle.
REQ-043 Mid-operation reset: clr during a granted read -> no rvalid; sweep restarts at address 0; requests ignored for 16 cycles.
REQ-044 Request during sweep: req_f=1 through CLEAR -> gnt_f=0 until busy falls, then granted that cycle.
